// File: rtl/move_input_conditioner.sv
// Move input conditioner: synchronizes and debounces the select and game-reset
// pushbuttons, snapshots the cell switches on an accepted select press and
// classifies the snapshot as a legal (one-hot) move or an error.

// One debounce FSM per button. The accept strobe is combinational and is
// registered by the parent, so the press latency is 2 + DEBOUNCE_CYCLES clocks.
module move_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,      // synchronized, active-low button
    output logic accept,   // press accepted this cycle
    output logic held      // FSM is in HELD
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    // The counter is cleared on entry to a wait state, so it reads N-2 on the
    // N-th consecutive stable sample; that sample is the one that accepts.
    localparam logic [19:0] LAST = 20'(DEBOUNCE_CYCLES - 2);

    state_t      state;
    logic [19:0] cnt;
    logic [19:0] cnt_inc;

    // Saturating increment: the counter never wraps back to zero.
    always_comb begin
        cnt_inc = (cnt == '1) ? cnt : cnt + 20'd1;
    end

    // Strobe fires in the same cycle the FSM moves from PRESS_WAIT to HELD.
    always_comb begin
        accept = (state == PRESS_WAIT) && !din && (cnt == LAST);
        held   = (state == HELD);
    end

    // Debounce state machine with its stable-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!din) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (din) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt == LAST) state <= HELD;
                    end
                end
                HELD: begin
                    if (din) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!din) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt == LAST) state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

module move_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       iRST_n,
    input  logic       select_raw,
    input  logic       rst_raw,
    input  logic [8:0] move_raw,
    output logic [8:0] move,
    output logic       move_pulse,
    output logic       move_error,
    output logic       game_rst_pulse
);
    logic       rst_meta;
    logic       rst_n;
    logic [1:0] sel_sync;
    logic [1:0] grst_sync;
    logic [8:0] move_meta;
    logic [8:0] move_sync;
    logic       sel_accept;
    logic       sel_held;
    logic       grst_accept;
    logic       grst_held;
    logic       one_hot;

    // Reset synchronizer: asserts asynchronously, releases on a clock edge.
    always_ff @(posedge MAX10_CLK1_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    // Input synchronizers. They already sample asynchronous inputs, so they
    // leave reset directly on iRST_n; the FSMs stay held for two more clocks
    // and see settled values, keeping press latency after reset at 2 + N.
    always_ff @(posedge MAX10_CLK1_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            sel_sync  <= 2'b11;
            grst_sync <= 2'b11;
            move_meta <= '0;
            move_sync <= '0;
        end else begin
            sel_sync  <= {sel_sync[0], select_raw};
            grst_sync <= {grst_sync[0], rst_raw};
            move_meta <= move_raw;
            move_sync <= move_meta;
        end
    end

    move_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_db (
        .clk    (MAX10_CLK1_50),
        .rst_n  (rst_n),
        .din    (sel_sync[1]),
        .accept (sel_accept),
        .held   (sel_held)
    );

    move_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_grst_db (
        .clk    (MAX10_CLK1_50),
        .rst_n  (rst_n),
        .din    (grst_sync[1]),
        .accept (grst_accept),
        .held   (grst_held)
    );

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    always_comb begin
        one_hot = (move_sync != 9'd0) && ((move_sync & (move_sync - 9'd1)) == 9'd0);
    end

    // Registered outputs. A game reset, accepted now or still held, takes
    // priority and suppresses the select press entirely.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            move           <= '0;
            move_pulse     <= 1'b0;
            move_error     <= 1'b0;
            game_rst_pulse <= 1'b0;
        end else begin
            move_pulse     <= 1'b0;
            move_error     <= 1'b0;
            game_rst_pulse <= grst_accept;
            if (sel_accept && !grst_accept && !grst_held) begin
                move       <= move_sync;
                move_pulse <= one_hot;
                move_error <= !one_hot;
            end
        end
    end

    // sel_held is informational only; keep it observably consumed.
    logic unused_ok;
    always_comb unused_ok = sel_held;
endmodule

// File: doc/move_input_conditioner.md
MOVE_INPUT_CONDITIONER -- requirements
Module: move_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable clock cycles needed to accept a press or release (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 MAX10_CLK1_50  in  1  sole clock (50 MHz); every flop in the block SHALL be clocked by it.
REQ-003 iRST_n  in  1  asynchronous active-low reset.
REQ-004 select_raw  in  1  raw select pushbutton, active-low, asynchronous, bouncing.
REQ-005 rst_raw  in  1  raw game-reset pushbutton, active-low, asynchronous, bouncing.
REQ-006 move_raw  in  9  raw slide switches, bit i selects board cell i (cell 0 top-left, cell 8 bottom-right), asynchronous.
REQ-007 move  out  9  registered switch snapshot taken at the accepted select press.
REQ-008 move_pulse  out  1  one-cycle strobe: a legal move has been latched on move.
REQ-009 move_error  out  1  one-cycle strobe: select was accepted but the snapshot was not one-hot.
REQ-010 game_rst_pulse  out  1  one-cycle strobe: debounced game-reset press.

Function
REQ-011 select_raw, rst_raw and move_raw SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Each button SHALL have an independent debounce FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a 20-bit stable counter.
REQ-013 IDLE: the synchronized input going low SHALL cause a transition to PRESS_WAIT and clear the counter.
REQ-014 PRESS_WAIT: the counter SHALL increment while the input stays low; if the input goes high, the FSM SHALL return to IDLE; when the counter reaches DEBOUNCE_CYCLES-1, the FSM SHALL go to HELD and fire the accept strobe in that same cycle.
REQ-015 HELD: the input going high SHALL cause a transition to RELEASE_WAIT and clear the counter; no further strobe SHALL fire while the button is held.
REQ-016 RELEASE_WAIT: the counter SHALL increment while the input stays high; if the input goes low, the FSM SHALL return to HELD with no strobe; when the counter reaches DEBOUNCE_CYCLES-1, the FSM SHALL go to IDLE.
REQ-017 Press latency SHALL be exactly 2 + DEBOUNCE_CYCLES clocks from a clean falling edge of the raw input to assertion of the output strobe, with the outputs registered.
REQ-018 When the select accept strobe fires, move SHALL be loaded with the synchronized move_raw value from that same cycle.
REQ-019 In that same cycle, move_pulse SHALL be set if the loaded value has exactly one bit set, and move_error SHALL be set otherwise (zero bits or two or more bits).
REQ-020 move_pulse and move_error SHALL never be asserted in the same cycle.
REQ-021 move SHALL hold its value until the next accepted select press; later switch changes SHALL NOT alter it.
REQ-022 game_rst_pulse SHALL assert for one cycle per accepted rst_raw press.
REQ-023 Simultaneous accept of rst and select in the same cycle: game_rst_pulse SHALL assert, move_pulse and move_error SHALL stay low, and move SHALL remain unchanged.
REQ-024 While the rst debounce FSM is in HELD, select accepts SHALL be suppressed: no strobe, no update of move.
REQ-025 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no strobe.
REQ-026 The debounce counters SHALL saturate and never wrap.

Reset
REQ-027 On iRST_n low, all FSMs SHALL go to IDLE asynchronously.
REQ-028 On iRST_n low, the counters, synchronizers (loaded with 1 for the buttons and 0 for the switches), move (9'b0) and all strobes (0) SHALL clear asynchronously.
REQ-029 Reset deassertion SHALL be synchronized to MAX10_CLK1_50 before it is released to the flops.
REQ-030 A button held low through reset release SHALL be debounced as a fresh press: one strobe, 2 + DEBOUNCE_CYCLES clocks after the release.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 move_raw = 9'b000010000, select_raw held low for 20 clocks -> exactly one move_pulse, 6 clocks after the falling edge, with move = 9'b000010000 and move_error = 0.
REQ-032 move_raw = 9'b000000011, clean select press -> exactly one move_error pulse, move = 9'b000000011, move_pulse never asserted.
REQ-033 select_raw toggling every 2 clocks for 30 clocks, then released -> no move_pulse, no move_error.
REQ-034 rst_raw and select_raw fall in the same cycle -> one game_rst_pulse, no move_pulse, move unchanged.
REQ-035 iRST_n asserted in the PRESS_WAIT state (select counter = 2) -> all outputs 0 immediately; after release with select still low, one move_pulse 6 clocks later.
REQ-036 Select held for 100 clocks, released for 1 clock, then low again -> a single move_pulse total.
